// File: rtl/ram_arb_pkg.sv
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared types for the RAM data-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

    typedef struct packed {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    localparam int N_REQ = 2;

endpackage

`default_nettype wire

// File: rtl/ram_arb_pick.sv
// ============================================================================
// Module      : ram_arb_pick
// Description : Combinational winner select for the two RAM data-port masters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arb_pick
    import ram_arb_pkg::*;
#(
    parameter int STARVE_MAX = 7,
    parameter bit CPU_PRIO   = 1'b1,
    parameter int CNT_W      = 3
) (
    input  logic [N_REQ-1:0] req_i,
    input  owner_e           last_winner_i,
    input  logic [CNT_W-1:0] starve_cnt_i,
    output logic [N_REQ-1:0] gnt_o,
    output owner_e           winner_o
);

    logic w_prio_m1;
    logic w_rr_m1;
    logic w_pick_m1;

    // Contended case only: M1 wins under priority mode when starved, under
    // round-robin mode when M0 took the previous grant.
    assign w_prio_m1 = (starve_cnt_i == CNT_W'(STARVE_MAX));
    assign w_rr_m1   = (last_winner_i == OWN_M0);

    always_comb begin
        w_pick_m1 = 1'b0;
        if (req_i[1]) begin
            if (!req_i[0]) begin
                w_pick_m1 = 1'b1;
            end else begin
                w_pick_m1 = CPU_PRIO ? w_prio_m1 : w_rr_m1;
            end
        end
    end

    assign gnt_o    = {w_pick_m1, req_i[0] & ~w_pick_m1};
    assign winner_o = w_pick_m1 ? OWN_M1 : OWN_M0;

endmodule

`default_nettype wire

// File: rtl/ram_data_arbiter.sv
// ============================================================================
// Module      : ram_data_arbiter
// Description : Shares the block-RAM data port between the CPU (M0) and the
//               boot loader / debug DMA (M1); routes read data to its owner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_data_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int STARVE_MAX = 7,
    parameter bit CPU_PRIO   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic [3:0]        m0_wen,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,

    input  logic              m1_req,
    input  logic [3:0]        m1_wen,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,

    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    mem_req_t          w_req0;
    mem_req_t          w_req1;
    mem_req_t          w_sel;
    logic [N_REQ-1:0]  w_pick_gnt;
    logic [N_REQ-1:0]  w_gnt;
    logic              w_any;
    logic              w_is_read;
    owner_e            w_winner;
    logic              w_unused_addr_bits;

    owner_e            last_winner_q, last_winner_d;
    logic [CNT_W-1:0]  starve_cnt_q,  starve_cnt_d;

    logic              ram_en_q;
    logic [3:0]        ram_wen_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [31:0]       ram_wdata_q;

    // Shadow pipe: s1 lines up with ram_*, s2 with ram_rdata.
    logic              s1_rd_q, s2_rd_q;
    owner_e            s1_own_q, s2_own_q;

    assign w_req0 = '{wen: m0_wen, addr: m0_addr, wdata: m0_wdata};
    assign w_req1 = '{wen: m1_wen, addr: m1_addr, wdata: m1_wdata};

    ram_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CPU_PRIO   (CPU_PRIO),
        .CNT_W      (CNT_W)
    ) u_pick (
        .req_i         ({m1_req, m0_req}),
        .last_winner_i (last_winner_q),
        .starve_cnt_i  (starve_cnt_q),
        .gnt_o         (w_pick_gnt),
        .winner_o      (w_winner)
    );

    // No grant is offered while reset is held, so nothing can be accepted and lost.
    assign w_gnt     = w_pick_gnt & {N_REQ{rst}};
    assign w_any     = |w_gnt;
    assign w_sel     = w_gnt[1] ? w_req1 : w_req0;
    assign w_is_read = (w_sel.wen == 4'b0000);

    assign w_unused_addr_bits = ^{w_sel.addr[31:ADDR_W+2], w_sel.addr[1:0]};

    assign last_winner_d = w_any ? w_winner : last_winner_q;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!m1_req || w_gnt[1]) begin
            starve_cnt_d = '0;
        end else if (w_gnt[0] && (starve_cnt_q != CNT_W'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_en_q      <= 1'b0;
            ram_wen_q     <= 4'b0000;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            s1_rd_q       <= 1'b0;
            s1_own_q      <= OWN_M0;
            s2_rd_q       <= 1'b0;
            s2_own_q      <= OWN_M0;
            last_winner_q <= OWN_M1;
            starve_cnt_q  <= '0;
        end else begin
            ram_en_q  <= w_any;
            ram_wen_q <= w_any ? w_sel.wen : 4'b0000;
            if (w_any) begin
                ram_addr_q  <= w_sel.addr[ADDR_W+1:2];
                ram_wdata_q <= w_sel.wdata;
            end
            s1_rd_q       <= w_any & w_is_read;
            s1_own_q      <= w_winner;
            s2_rd_q       <= s1_rd_q;
            s2_own_q      <= s1_own_q;
            last_winner_q <= last_winner_d;
            starve_cnt_q  <= starve_cnt_d;
        end
    end

    assign m0_gnt    = w_gnt[0];
    assign m1_gnt    = w_gnt[1];

    assign ram_en    = ram_en_q;
    assign ram_wen   = ram_wen_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

    assign m0_rvalid = s2_rd_q & (s2_own_q == OWN_M0);
    assign m1_rvalid = s2_rd_q & (s2_own_q == OWN_M1);
    assign m0_rdata  = m0_rvalid ? ram_rdata : 32'h0;
    assign m1_rdata  = m1_rvalid ? ram_rdata : 32'h0;

endmodule

`default_nettype wire
